// File: rtl/ball_engine.sv
// rtl/ball_engine.sv - Pong ball physics: serve/play FSM, wall and paddle bounces, scoring.
module ball_engine #(
  parameter int FIELD_W         = 128,
  parameter int FIELD_H         = 64,
  parameter int BALL_HALF       = 2,
  parameter int PADDLE_HALF     = 8,
  parameter int TOP_PADDLE_Y    = 3,
  parameter int BOTTOM_PADDLE_Y = 60,
  parameter int MAX_DY          = 3,
  parameter int SPEEDUP_HITS    = 4,
  parameter int SERVE_DELAY     = 30
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       move_tick,
  input  logic                       serve_en,
  input  logic [$clog2(FIELD_W)-1:0] topPaddleX,
  input  logic [$clog2(FIELD_W)-1:0] bottomPaddleX,
  output logic [$clog2(FIELD_W)-1:0] ballX,
  output logic [$clog2(FIELD_H)-1:0] ballY,
  output logic signed [2:0]          dx,
  output logic signed [2:0]          dy,
  output logic                       paddle_hit,
  output logic                       score_top,
  output logic                       score_bottom,
  output logic                       in_play
);
  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  localparam int SW = ((XW > YW) ? XW : YW) + 2;
  localparam int CW = $clog2(SERVE_DELAY + 1);
  localparam int RW = $clog2(SPEEDUP_HITS + 1);

  localparam logic signed [SW-1:0] ZERO_S = '0;
  localparam logic signed [SW-1:0] BH_S   = SW'(BALL_HALF);
  localparam logic signed [SW-1:0] PH_S   = SW'(PADDLE_HALF);
  localparam logic signed [SW-1:0] TLIM_S = SW'(TOP_PADDLE_Y + 1);
  localparam logic signed [SW-1:0] BLIM_S = SW'(BOTTOM_PADDLE_Y - 1);
  localparam logic signed [SW-1:0] XEDGE_S = SW'(FIELD_W - 1);
  localparam logic signed [SW-1:0] YEDGE_S = SW'(FIELD_H - 1);
  localparam logic signed [SW-1:0] XLO_S  = SW'(BALL_HALF);
  localparam logic signed [SW-1:0] XHI_S  = SW'(FIELD_W - 1 - BALL_HALF);
  localparam logic signed [SW-1:0] Z1_S   = SW'(PADDLE_HALF / 4);
  localparam logic signed [SW-1:0] Z2_S   = SW'(3 * PADDLE_HALF / 4);
  localparam logic signed [SW-1:0] NZ1_S  = SW'(-(PADDLE_HALF / 4));
  localparam logic signed [SW-1:0] NZ2_S  = SW'(-(3 * PADDLE_HALF / 4));
  localparam logic [XW-1:0]        X_CTR  = XW'(FIELD_W / 2);
  localparam logic [YW-1:0]        Y_CTR  = YW'(FIELD_H / 2);
  localparam logic [CW-1:0]        CNT_MAX = CW'(SERVE_DELAY);
  localparam logic [RW-1:0]        RALLY_LAST = RW'(SPEEDUP_HITS - 1);
  localparam logic [1:0]           MAG_MAX = 2'(MAX_DY);
  localparam logic signed [2:0]    DY_UP  = 3'sb111;
  localparam logic signed [2:0]    DY_DN  = 3'sb001;

  typedef enum logic {S_SERVE, S_PLAY} state_t;

  state_t             state_q;
  logic [XW-1:0]      ballX_q, x_d;
  logic [YW-1:0]      ballY_q, y_d;
  logic signed [2:0]  dx_q, dy_q, dx_d, dy_d, dx_wall, dx_pad;
  logic [CW-1:0]      cnt_q;
  logic [RW-1:0]      rally_q, rally_d;
  logic               hit_q, st_q, sb_q, play_q;

  logic signed [SW-1:0] bx, by, tpx, bpx, left, right, top, bot, off, xs;
  logic               dx_neg, dx_pos, dy_neg, dy_pos;
  logic               hit_top, hit_bot, hit, miss_top, miss_bot, wrap;
  logic [1:0]         mag, mag_n;

  assign bx  = $signed({{(SW-XW){1'b0}}, ballX_q});
  assign by  = $signed({{(SW-YW){1'b0}}, ballY_q});
  assign tpx = $signed({{(SW-XW){1'b0}}, topPaddleX});
  assign bpx = $signed({{(SW-XW){1'b0}}, bottomPaddleX});

  always_comb begin
    left   = bx - BH_S;
    right  = bx + BH_S;
    top    = by - BH_S;
    bot    = by + BH_S;
    dx_neg = dx_q[2];
    dx_pos = !dx_q[2] && (dx_q != 3'sd0);
    dy_neg = dy_q[2];
    dy_pos = !dy_q[2] && (dy_q != 3'sd0);

    dx_wall = ((left <= ZERO_S && dx_neg) || (right >= XEDGE_S && dx_pos)) ? -dx_q : dx_q;

    hit_top = dy_neg && (top <= TLIM_S) && (right >= tpx - PH_S) && (left <= tpx + PH_S);
    hit_bot = dy_pos && (bot >= BLIM_S) && (right >= bpx - PH_S) && (left <= bpx + PH_S);
    hit     = hit_top || hit_bot;
    miss_top = !hit && dy_neg && (top <= ZERO_S);
    miss_bot = !hit && dy_pos && (bot >= YEDGE_S);

    // English-style deflection: where the ball meets the paddle sets its new horizontal speed
    off = bx - (hit_top ? tpx : bpx);
    if (off <= NZ2_S)      dx_pad = -3'sd2;
    else if (off <= NZ1_S) dx_pad = -3'sd1;
    else if (off < Z1_S)   dx_pad = 3'sd0;
    else if (off < Z2_S)   dx_pad = 3'sd1;
    else                   dx_pad = 3'sd2;

    wrap    = hit && (rally_q == RALLY_LAST);
    rally_d = wrap ? '0 : rally_q + RW'(1);
    mag     = dy_q[2] ? (~dy_q[1:0] + 2'd1) : dy_q[1:0];
    mag_n   = (wrap && mag < MAG_MAX) ? mag + 2'd1 : mag;

    dx_d = hit ? dx_pad : dx_wall;
    if (hit) dy_d = dy_neg ? $signed({1'b0, mag_n}) : -$signed({1'b0, mag_n});
    else     dy_d = dy_q;

    xs = bx + $signed({{(SW-3){dx_d[2]}}, dx_d});
    if (xs < XLO_S)      x_d = XLO_S[XW-1:0];
    else if (xs > XHI_S) x_d = XHI_S[XW-1:0];
    else                 x_d = xs[XW-1:0];
    y_d = ballY_q + {{(YW-3){dy_d[2]}}, dy_d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_SERVE;
      ballX_q <= X_CTR;
      ballY_q <= Y_CTR;
      dx_q    <= '0;
      dy_q    <= DY_UP;
      cnt_q   <= '0;
      rally_q <= '0;
      hit_q   <= 1'b0;
      st_q    <= 1'b0;
      sb_q    <= 1'b0;
      play_q  <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      st_q  <= 1'b0;
      sb_q  <= 1'b0;
      if (move_tick) begin
        case (state_q)
          S_SERVE: begin
            if (cnt_q == CNT_MAX && serve_en) begin
              state_q <= S_PLAY;
              play_q  <= 1'b1;
              cnt_q   <= '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_PLAY: begin
            if (miss_top || miss_bot) begin
              state_q <= S_SERVE;
              play_q  <= 1'b0;
              ballX_q <= X_CTR;
              ballY_q <= Y_CTR;
              dx_q    <= '0;
              dy_q    <= miss_top ? DY_UP : DY_DN;
              rally_q <= '0;
              cnt_q   <= '0;
              sb_q    <= miss_top;
              st_q    <= miss_bot;
            end else begin
              ballX_q <= x_d;
              ballY_q <= y_d;
              dx_q    <= dx_d;
              dy_q    <= dy_d;
              hit_q   <= hit;
              if (hit) rally_q <= rally_d;
            end
          end
          default: state_q <= S_SERVE;
        endcase
      end
    end
  end

  assign ballX        = ballX_q;
  assign ballY        = ballY_q;
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign paddle_hit   = hit_q;
  assign score_top    = st_q;
  assign score_bottom = sb_q;
  assign in_play      = play_q;
endmodule

// File: tb/tb_ball_engine.sv
// tb/tb_ball_engine.sv - directed stimulus with a behavioural physics model and pinned literal checks.
module tb_ball_engine;
  localparam int FW = 128, FH = 64, BH = 2, PH = 8, TPY = 3, BPY = 60;
  localparam int MAXDY = 3, SPH = 4, SD = 30;
  localparam int DC = -99;

  logic clk = 1'b0, rst = 1'b0, move_tick = 1'b0, serve_en = 1'b0;
  logic [6:0] topPaddleX = 7'd70, bottomPaddleX = 7'd64;
  logic [6:0] ballX;
  logic [5:0] ballY;
  logic signed [2:0] dx, dy;
  logic paddle_hit, score_top, score_bottom, in_play;

  ball_engine dut (
    .clk(clk), .rst(rst), .move_tick(move_tick), .serve_en(serve_en),
    .topPaddleX(topPaddleX), .bottomPaddleX(bottomPaddleX),
    .ballX(ballX), .ballY(ballY), .dx(dx), .dy(dy),
    .paddle_hit(paddle_hit), .score_top(score_top), .score_bottom(score_bottom),
    .in_play(in_play)
  );

  always #5 clk = ~clk;

  int mp = 0, mx = FW / 2, my = FH / 2, mdx = 0, mdy = -1, mcnt = 0, mrally = 0;
  int mhit = 0, mst = 0, msb = 0;
  int p_x = DC, p_y = DC, p_dx = DC, p_dy = DC, p_play = DC, p_hit = DC, p_st = DC, p_sb = DC;
  int tmo_cnt = 0, tmo_seen = 0;
  int vectors = 0, miscompares = 0;
  event chk_now;

  function automatic int zone(input int off);
    if (off <= -(3 * PH / 4)) return -2;
    if (off <= -(PH / 4))     return -1;
    if (off < PH / 4)         return 0;
    if (off < 3 * PH / 4)     return 1;
    return 2;
  endfunction

  task automatic model_reset();
    mp = 0; mx = FW / 2; my = FH / 2; mdx = 0; mdy = -1; mcnt = 0; mrally = 0;
    mhit = 0; mst = 0; msb = 0;
  endtask

  task automatic model_step(input logic mt);
    int ndx, ndy, mag, tp, bp;
    bit ht, hb;
    mhit = 0; mst = 0; msb = 0;
    if (!rst) begin
      model_reset();
    end else if (mt) begin
      if (mp == 0) begin
        if (mcnt == SD && serve_en) begin mp = 1; mcnt = 0; end
        else if (mcnt < SD) mcnt++;
      end else begin
        tp = int'(topPaddleX); bp = int'(bottomPaddleX);
        ndx = mdx;
        if ((mx - BH <= 0 && mdx < 0) || (mx + BH >= FW - 1 && mdx > 0)) ndx = -mdx;
        ht = mdy < 0 && my - BH <= TPY + 1 && mx + BH >= tp - PH && mx - BH <= tp + PH;
        hb = mdy > 0 && my + BH >= BPY - 1 && mx + BH >= bp - PH && mx - BH <= bp + PH;
        ndy = mdy;
        if (ht || hb) begin
          ndx = zone(mx - (ht ? tp : bp));
          mag = (mdy < 0) ? -mdy : mdy;
          mrally++;
          if (mrally == SPH) begin
            mrally = 0;
            if (mag < MAXDY) mag++;
          end
          ndy = (mdy < 0) ? mag : -mag;
          mhit = 1;
        end
        if (!(ht || hb) && mdy < 0 && my - BH <= 0) begin
          msb = 1; mp = 0; mx = FW / 2; my = FH / 2; mdx = 0; mdy = -1; mrally = 0; mcnt = 0;
        end else if (!(ht || hb) && mdy > 0 && my + BH >= FH - 1) begin
          mst = 1; mp = 0; mx = FW / 2; my = FH / 2; mdx = 0; mdy = 1; mrally = 0; mcnt = 0;
        end else begin
          mdx = ndx; mdy = ndy;
          mx = mx + ndx;
          if (mx < BH) mx = BH;
          if (mx > FW - 1 - BH) mx = FW - 1 - BH;
          my = my + ndy;
        end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always begin
    @(negedge clk or chk_now);
    cmp("ballX", int'(ballX), mx);
    cmp("ballY", int'(ballY), my);
    cmp("dx", int'(dx), mdx);
    cmp("dy", int'(dy), mdy);
    cmp("in_play", int'(in_play), mp);
    cmp("paddle_hit", int'(paddle_hit), mhit);
    cmp("score_top", int'(score_top), mst);
    cmp("score_bottom", int'(score_bottom), msb);
    if (p_x != DC)    cmp("pin_ballX", int'(ballX), p_x);
    if (p_y != DC)    cmp("pin_ballY", int'(ballY), p_y);
    if (p_dx != DC)   cmp("pin_dx", int'(dx), p_dx);
    if (p_dy != DC)   cmp("pin_dy", int'(dy), p_dy);
    if (p_play != DC) cmp("pin_in_play", int'(in_play), p_play);
    if (p_hit != DC)  cmp("pin_paddle_hit", int'(paddle_hit), p_hit);
    if (p_st != DC)   cmp("pin_score_top", int'(score_top), p_st);
    if (p_sb != DC)   cmp("pin_score_bottom", int'(score_bottom), p_sb);
    if (tmo_cnt != tmo_seen) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d expired waits, expected %0d", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
  end

  task automatic pin(input int x, input int y, input int vdx, input int vdy,
                     input int play, input int hit, input int st, input int sb);
    p_x = x; p_y = y; p_dx = vdx; p_dy = vdy; p_play = play; p_hit = hit; p_st = st; p_sb = sb;
  endtask

  task automatic cyc(input logic mt);
    move_tick = mt;
    @(posedge clk);
    pin(DC, DC, DC, DC, DC, DC, DC, DC);
    model_step(mt);
    #1;
    move_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input bit idle_between);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      if (idle_between) cyc(1'b0);
    end
  endtask

  task automatic tick_until_y(input int y, input int lim);
    int k = 0;
    while (my != y && k < lim) begin cyc(1'b1); k++; end
    if (my != y) tmo_cnt++;
  endtask

  task automatic tick_until_x(input int x, input int lim);
    int k = 0;
    while (mx != x && k < lim) begin cyc(1'b1); k++; end
    if (mx != x) tmo_cnt++;
  endtask

  initial begin
    int hits, k;
    serve_en = 1'b1;
    cyc(1'b0);
    pin(64, 32, 0, -1, 0, 0, 0, 0);
    cyc(1'b1);
    pin(64, 32, 0, -1, 0, 0, 0, 0);
    rst = 1'b1;

    ticks(SD, 1'b1);
    pin(64, 32, 0, -1, 0, 0, 0, 0);
    cyc(1'b1);
    pin(64, 32, 0, -1, 1, 0, 0, 0);

    tick_until_y(6, 40);
    pin(64, 6, 0, -1, 1, 0, 0, 0);
    cyc(1'b1);
    pin(62, 7, -2, 1, 1, 1, 0, 0);

    bottomPaddleX = 7'd0;
    tick_until_x(2, 40);
    pin(2, 37, -2, 1, 1, 0, 0, 0);
    cyc(1'b1);
    pin(4, 38, 2, 1, 1, 0, 0, 0);

    k = 0;
    while (mst == 0 && k < 100) begin cyc(1'b1); k++; end
    if (mst == 0) tmo_cnt++;
    pin(64, 32, 0, 1, 0, 0, 1, 0);

    serve_en = 1'b0;
    ticks(SD + 5, 1'b1);
    pin(64, 32, 0, 1, 0, 0, 0, 0);
    serve_en = 1'b1;
    cyc(1'b1);
    pin(64, 32, 0, 1, 1, 0, 0, 0);

    bottomPaddleX = 7'd64;
    topPaddleX = 7'd100;
    tick_until_y(57, 40);
    cyc(1'b1);
    pin(64, 56, 0, -1, 1, 1, 0, 0);
    tick_until_y(3, 80);
    pin(64, 3, 0, -1, 1, 0, 0, 0);
    cyc(1'b1);
    pin(64, 2, 0, -1, 1, 0, 0, 0);
    cyc(1'b1);
    pin(64, 32, 0, -1, 0, 0, 0, 1);

    topPaddleX = 7'd64;
    ticks(SD + 1, 1'b0);
    pin(64, 32, 0, -1, 1, 0, 0, 0);
    hits = 0; k = 0;
    while (hits < 12 && k < 2000) begin
      cyc(1'b1);
      k++;
      if (mhit != 0) begin
        hits++;
        if (hits == 4)  pin(64, DC, 0, -2, 1, 1, 0, 0);
        if (hits == 8)  pin(64, DC, 0, -3, 1, 1, 0, 0);
        if (hits == 12) pin(64, DC, 0, -3, 1, 1, 0, 0);
      end
    end
    if (hits < 12) tmo_cnt++;

    ticks(5, 1'b0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    pin(64, 32, 0, -1, 0, 0, 0, 0);
    -> chk_now;
    cyc(1'b1);
    pin(64, 32, 0, -1, 0, 0, 0, 0);
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
